mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: request/grant data-bus handshake with byte strobes,
// load extraction and extension, and a pipeline stall until the access completes.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] write_data_M,
  input  logic        we_mem_M,
  input  logic [3:0]  ls_type_M,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        stall_M,
  output logic [31:0] load_data_M,
  output logic        misalign_M
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_G, S_WAIT_R, S_DONE} state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_load_data;

  size_t       w_size;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_unsigned;
  logic        w_misaligned;
  logic        w_access;
  logic        w_req;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_fmt;

  // Type decode; a code whose direction disagrees with we_mem_M decodes as a no-op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_size     = SZ_NONE;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_unsigned = 1'b0;
    unique case (ls_type_M)
      4'b0001: begin w_size = SZ_BYTE; w_is_load = ~we_mem_M; end
      4'b0010: begin w_size = SZ_HALF; w_is_load = ~we_mem_M; end
      4'b0011: begin w_size = SZ_WORD; w_is_load = ~we_mem_M; end
      4'b0100: begin w_size = SZ_BYTE; w_is_load = ~we_mem_M; w_unsigned = 1'b1; end
      4'b0101: begin w_size = SZ_HALF; w_is_load = ~we_mem_M; w_unsigned = 1'b1; end
      4'b1001: begin w_size = SZ_BYTE; w_is_store = we_mem_M; end
      4'b1010: begin w_size = SZ_HALF; w_is_store = we_mem_M; end
      4'b1011: begin w_size = SZ_WORD; w_is_store = we_mem_M; end
      default: ;
    endcase
  end

  assign w_misaligned = ((w_size == SZ_HALF) && ALU_result_M[0]) ||
                        ((w_size == SZ_WORD) && (ALU_result_M[1:0] != 2'b00));
  assign w_access     = (w_is_load || w_is_store) && !w_misaligned;

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_req = 1'b1;
          if (dbus_gnt) w_next = w_is_load ? S_WAIT_R : S_DONE;
          else          w_next = S_WAIT_G;
        end
      end
      S_WAIT_G: begin
        w_req = 1'b1;
        if (dbus_gnt) w_next = w_is_load ? S_WAIT_R : S_DONE;
      end
      S_WAIT_R: if (dbus_rvalid) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Store lanes: data is replicated so the addressed lane always carries it.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    unique case (w_size)
      SZ_BYTE: begin w_be = 4'b0001 << ALU_result_M[1:0]; w_wdata = {4{write_data_M[7:0]}}; end
      SZ_HALF: begin w_be = ALU_result_M[1] ? 4'b1100 : 4'b0011; w_wdata = {2{write_data_M[15:0]}}; end
      SZ_WORD: begin w_be = 4'b1111; w_wdata = write_data_M; end
      default: ;
    endcase
  end

  always_comb begin
    unique case (ALU_result_M[1:0])
      2'd0:    w_byte = dbus_rdata[7:0];
      2'd1:    w_byte = dbus_rdata[15:8];
      2'd2:    w_byte = dbus_rdata[23:16];
      default: w_byte = dbus_rdata[31:24];
    endcase
    w_half     = ALU_result_M[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    w_load_fmt = dbus_rdata;
    unique case (w_size)
      SZ_BYTE: w_load_fmt = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load_fmt = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: ;
    endcase
  end

  // Everything is forced low during reset so an interrupted request drops immediately.
  assign dbus_req    = w_req && !rst;
  assign dbus_we     = dbus_req && w_is_store;
  assign dbus_be     = (dbus_req && w_is_store) ? w_be : 4'b0000;
  assign dbus_wdata  = (dbus_req && w_is_store) ? w_wdata : 32'h0;
  assign dbus_addr   = dbus_req ? {ALU_result_M[31:2], 2'b00} : 32'h0;
  assign stall_M     = !rst && (((r_state == S_IDLE) && w_access) ||
                                (r_state == S_WAIT_G) || (r_state == S_WAIT_R));
  assign misalign_M  = !rst && (w_is_load || w_is_store) && w_misaligned;
  assign load_data_M = r_load_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_load_data <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_next;
      if ((r_state == S_WAIT_R) && dbus_rvalid) r_load_data <= w_load_fmt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes expected bus requests and
// completions computed from plain arithmetic; an independent monitor pops and compares.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALU_result_M;
  logic [31:0] write_data_M;
  logic        we_mem_M;
  logic [3:0]  ls_type_M;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        stall_M;
  logic [31:0] load_data_M;
  logic        misalign_M;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .ALU_result_M(ALU_result_M), .write_data_M(write_data_M),
    .we_mem_M(we_mem_M), .ls_type_M(ls_type_M),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .stall_M(stall_M), .load_data_M(load_data_M), .misalign_M(misalign_M)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] data;
    int          stall;
  } done_exp_t;

  bus_exp_t    bus_q[$];
  done_exp_t   done_q[$];
  logic [31:0] mis_q[$];
  logic [31:0] model_ld = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic report_unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: DUT event with no expected entry", name);
  endtask

  // Monitor: bus requests, misalign flags and access completions, all sampled mid-cycle.
  int mon_len  = 0;
  bit mon_prev = 1'b0;
  always @(negedge clk) begin
    bus_exp_t  be_e;
    done_exp_t de;
    logic [31:0] ma;
    if (rst) begin
      mon_len  = 0;
      mon_prev = 1'b0;
    end else begin
      if (!dbus_req) begin
        check("idle_we_be", {27'h0, dbus_we, dbus_be}, 32'h0);
        check("idle_wdata", dbus_wdata, 32'h0);
      end
      if (dbus_req && dbus_gnt) begin
        if (bus_q.size() == 0) report_unexpected("bus_req");
        else begin
          be_e = bus_q.pop_front();
          check("bus_addr", dbus_addr, be_e.addr);
          check("bus_we", {31'h0, dbus_we}, {31'h0, be_e.we});
          check("bus_be", {28'h0, dbus_be}, {28'h0, be_e.be});
          check("bus_wdata", dbus_wdata, be_e.wdata);
        end
      end
      if (misalign_M) begin
        if (mis_q.size() == 0) report_unexpected("misalign");
        else begin
          ma = mis_q.pop_front();
          check("mis_addr", ALU_result_M, ma);
          check("mis_req_stall", {30'h0, dbus_req, stall_M}, 32'h0);
        end
      end
      if (stall_M) begin
        mon_len++;
        mon_prev = 1'b1;
      end else if (mon_prev) begin
        if (done_q.size() == 0) report_unexpected("completion");
        else begin
          de = done_q.pop_front();
          check("load_data", load_data_M, de.data);
          check("stall_cycles", mon_len, de.stall);
        end
        mon_len  = 0;
        mon_prev = 1'b0;
      end
    end
  end

  // Reference model + open-loop driver for one access with grant delay g and rvalid delay r.
  task automatic do_access(input logic [3:0] t, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
    int          nb = 0;
    bit          sgn = 1'b0;
    bit          is_ld, is_st, mis;
    int          off;
    int          total;
    int          stall;
    int          rv_cycle;
    logic [31:0] mask, v, wdata;
    logic [3:0]  be;
    bus_exp_t    b;
    done_exp_t   d;
    case (t)
      4'd1:  begin nb = 1; sgn = 1'b1; end
      4'd2:  begin nb = 2; sgn = 1'b1; end
      4'd3:  nb = 4;
      4'd4:  nb = 1;
      4'd5:  nb = 2;
      4'd9:  nb = 1;
      4'd10: nb = 2;
      4'd11: nb = 4;
      default: nb = 0;
    endcase
    is_ld = (t inside {[4'd1:4'd5]}) && !we;
    is_st = (t inside {[4'd9:4'd11]}) && we;
    off   = int'(a[1:0]);
    mis   = (is_ld || is_st) && ((off % nb) != 0);
    stall = 0;
    rv_cycle = -1;
    if (mis) begin
      mis_q.push_back(a);
      g = 0;
    end else if (is_ld || is_st) begin
      mask  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      be    = 4'(((1 << nb) - 1) << off);
      wdata = 32'h0;
      for (int k = 0; k < 4 / nb; k++) wdata = wdata | ((wd & mask) << (8 * nb * k));
      b.addr  = a & 32'hFFFF_FFFC;
      b.we    = is_st;
      b.be    = is_st ? be : 4'h0;
      b.wdata = is_st ? wdata : 32'h0;
      bus_q.push_back(b);
      if (is_ld) begin
        v = (rd >> (8 * off)) & mask;
        if (sgn && v[8 * nb - 1]) v = v | ~mask;
        model_ld = v;
        stall    = g + r + 2;
        rv_cycle = g + 1 + r;
      end else begin
        stall = g + 1;
      end
      d.data  = model_ld;
      d.stall = stall;
      done_q.push_back(d);
    end else begin
      g = 0;
    end
    total = (stall > 0) ? stall + 1 : 1;
    ls_type_M    = t;
    we_mem_M     = we;
    ALU_result_M = a;
    write_data_M = wd;
    for (int c = 0; c < total; c++) begin
      dbus_gnt = (c == g) || ((c > g) && ($urandom_range(0, 1) == 1));
      if (c == rv_cycle) begin
        dbus_rvalid = 1'b1;
        dbus_rdata  = rd;
      end else if (!is_ld || c <= g || c > rv_cycle) begin
        dbus_rvalid = ($urandom_range(0, 1) == 1);
        dbus_rdata  = $urandom;
      end else begin
        dbus_rvalid = 1'b0;
        dbus_rdata  = $urandom;
      end
      @(posedge clk);
      #1;
    end
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes[11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd6, 4'd15};
    logic [3:0] t;
    logic       we;

    rst          = 1'b1;
    ls_type_M    = 4'd11;
    we_mem_M     = 1'b1;
    ALU_result_M = 32'h0000_0100;
    write_data_M = 32'h1234_5678;
    dbus_gnt     = 1'b1;
    dbus_rvalid  = 1'b1;
    dbus_rdata   = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_req_we_stall_mis", {28'h0, dbus_req, dbus_we, stall_M, misalign_M}, 32'h0);
    check("rst_addr", dbus_addr, 32'h0);
    check("rst_wdata", dbus_wdata, 32'h0);
    check("rst_be", {28'h0, dbus_be}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_load_data", load_data_M, 32'h0);
    rst         = 1'b0;
    ls_type_M   = 4'd0;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    @(posedge clk);
    #1;

    do_access(4'd11, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    do_access(4'd9,  1'b1, 32'h0000_0103, 32'h0000_00A5, 32'h0, 1, 0);
    do_access(4'd10, 1'b1, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 0, 0);
    do_access(4'd1,  1'b0, 32'h0000_0201, 32'h0, 32'h0000_80FF, 2, 1);
    do_access(4'd4,  1'b0, 32'h0000_0201, 32'h0, 32'h0000_80FF, 0, 0);
    do_access(4'd2,  1'b0, 32'h0000_0202, 32'h0, 32'h8001_1234, 0, 0);
    do_access(4'd5,  1'b0, 32'h0000_0202, 32'h0, 32'h8001_1234, 1, 2);
    do_access(4'd3,  1'b0, 32'h0000_0200, 32'h0, 32'h8001_1234, 0, 0);
    do_access(4'd3,  1'b0, 32'h0000_0206, 32'h0, 32'h0, 0, 0);
    do_access(4'd10, 1'b1, 32'h0000_0301, 32'hFFFF_FFFF, 32'h0, 0, 0);
    do_access(4'd9,  1'b0, 32'h0000_0300, 32'h55, 32'h0, 0, 0);
    do_access(4'd3,  1'b1, 32'h0000_0300, 32'h55, 32'h0, 0, 0);
    do_access(4'd7,  1'b0, 32'h0000_0300, 32'h55, 32'h0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      t  = codes[$urandom_range(0, 10)];
      we = (t[3]) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      do_access(t, we, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset arriving while a load waits for its data; the late rvalid must be dropped.
    bus_q.push_back('{addr: 32'h0000_0400, we: 1'b0, be: 4'h0, wdata: 32'h0});
    ls_type_M    = 4'd3;
    we_mem_M     = 1'b0;
    ALU_result_M = 32'h0000_0400;
    dbus_gnt     = 1'b1;
    dbus_rvalid  = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    dbus_gnt = 1'b0;
    @(negedge clk);
    check("rstmid_req_stall", {30'h0, dbus_req, stall_M}, 32'h0);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    ls_type_M   = 4'd0;
    dbus_rvalid = 1'b1;
    dbus_rdata  = 32'hCAFE_F00D;
    model_ld    = 32'h0;
    @(negedge clk);
    check("rstmid_idle_stall", {31'h0, stall_M}, 32'h0);
    check("rstmid_load_data", load_data_M, model_ld);
    @(posedge clk);
    #1;
    dbus_rvalid = 1'b0;
    check("rstmid_load_after", load_data_M, model_ld);
    @(posedge clk);
    #1;

    check("bus_q_drained", bus_q.size(), 32'h0);
    check("done_q_drained", done_q.size(), 32'h0);
    check("mis_q_drained", mis_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
